// File: rtl/beam_scan_controller_pkg.sv
// Shared widths, angle range and sequencer state encoding for the beam scan controller.
package beam_pkg;
    localparam int ANGLE_W    = 11;
    localparam int PCM_W      = 16;
    localparam int ANGLE_FULL = 2048;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        DRAIN,
        COMPARE,
        REPORT
    } scan_state_t;
endpackage

// File: rtl/beam_scan_controller_if.sv
// Control, PCM and DoA signals between the scan controller and its neighbours.
// BEAM_SCAN_THRESH_EN adds the energy_thresh input.
interface beam_scan_controller_if #(
    parameter int WINDOW_LOG2 = 8
);
    import beam_pkg::*;

    logic                          start;
    logic                          continuous;
    logic                          abort;
    logic signed [PCM_W-1:0]       pcm_data;
    logic                          pcm_valid;
    logic [ANGLE_W-1:0]            beam_angle;
    logic                          beam_enable;
    logic                          busy;
    logic [ANGLE_W-1:0]            doa_estimate;
    logic [32+WINDOW_LOG2-1:0]     doa_energy;
    logic                          doa_valid;
`ifdef BEAM_SCAN_THRESH_EN
    logic [32+WINDOW_LOG2-1:0]     energy_thresh;

    modport master (
        output start, continuous, abort, pcm_data, pcm_valid, energy_thresh,
        input  beam_angle, beam_enable, busy, doa_estimate, doa_energy, doa_valid
    );
    modport slave (
        input  start, continuous, abort, pcm_data, pcm_valid, energy_thresh,
        output beam_angle, beam_enable, busy, doa_estimate, doa_energy, doa_valid
    );
`else
    modport master (
        output start, continuous, abort, pcm_data, pcm_valid,
        input  beam_angle, beam_enable, busy, doa_estimate, doa_energy, doa_valid
    );
    modport slave (
        input  start, continuous, abort, pcm_data, pcm_valid,
        output beam_angle, beam_enable, busy, doa_estimate, doa_energy, doa_valid
    );
`endif
endinterface

// File: rtl/beam_scan_controller_energy_accumulator.sv
// Squares each enabled valid sample into a register, then adds it to the accumulator one cycle later.
// done is a same-cycle strobe on the last sample of the 2**WINDOW_LOG2 window.
module energy_accumulator
    import beam_pkg::*;
#(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      en,
    input  logic                      sample_valid,
    input  logic signed [PCM_W-1:0]   sample,
    output logic [32+WINDOW_LOG2-1:0] acc,
    output logic                      done
);
    localparam int AW = 32 + WINDOW_LOG2;

    logic signed [2*PCM_W-1:0] product;
    logic [31:0]               sq;
    logic                      sq_vld;
    logic [WINDOW_LOG2-1:0]    cnt;
    logic                      take;

    // Signed square is never negative; -32768^2 = 2^30 still fits 32 bits.
    assign product = sample * sample;
    assign take    = en && sample_valid;
    assign done    = take && (cnt == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sq     <= '0;
            sq_vld <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
        end else if (clr) begin
            sq     <= '0;
            sq_vld <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
        end else begin
            sq_vld <= take;
            if (take) begin
                sq  <= $unsigned(product);
                cnt <= cnt + 1'b1;
            end
            if (sq_vld) begin
                acc <= acc + AW'(sq);
            end
        end
    end
endmodule

// File: rtl/beam_scan_controller.sv
// Sweeps the steering angle around the circle, measures windowed energy per position, publishes the peak angle.
// BEAM_SCAN_THRESH_EN: publish only when the peak energy reaches energy_thresh.
module beam_scan_controller
    import beam_pkg::*;
#(
    parameter int ANGLE_STEP     = 64,
    parameter int SETTLE_SAMPLES = 48,
    parameter int WINDOW_LOG2    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    beam_scan_controller_if.slave bus
);
    localparam int                 AW          = 32 + WINDOW_LOG2;
    localparam logic [ANGLE_W-1:0] STEP        = ANGLE_W'(ANGLE_STEP);
    localparam logic [ANGLE_W-1:0] LAST_ANGLE  = ANGLE_W'(ANGLE_FULL - ANGLE_STEP);
    localparam logic [7:0]         SETTLE_LAST = 8'((SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1);

    scan_state_t        state, next_state;
    logic [ANGLE_W-1:0] angle, best_angle, new_angle, doa_est_q;
    logic [AW-1:0]      best, acc, new_best, doa_energy_q;
    logic [7:0]         settle_cnt;
    logic               first, doa_valid_q, acc_clr, acc_en, acc_done;
    logic               take, publish, aborting;

    energy_accumulator #(.WINDOW_LOG2(WINDOW_LOG2)) u_acc (
        .clk          (clk),
        .reset        (reset),
        .clr          (acc_clr),
        .en           (acc_en),
        .sample_valid (bus.pcm_valid),
        .sample       (bus.pcm_data),
        .acc          (acc),
        .done         (acc_done)
    );

    assign acc_en   = (state == ACCUM);
    assign aborting = bus.abort && (state != IDLE);
    // Strictly greater keeps the lower angle on ties.
    assign take      = first || (acc > best);
    assign new_best  = take ? acc : best;
    assign new_angle = take ? angle : best_angle;
`ifdef BEAM_SCAN_THRESH_EN
    assign publish = (new_best >= bus.energy_thresh);
`else
    assign publish = 1'b1;
`endif

    always_comb begin
        next_state = state;
        acc_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = SETTLE;
                    acc_clr    = 1'b1;
                end
            end
            SETTLE: begin
                if (SETTLE_SAMPLES == 0 || (bus.pcm_valid && settle_cnt == SETTLE_LAST)) begin
                    next_state = ACCUM;
                end
            end
            ACCUM:   if (acc_done) next_state = DRAIN;
            DRAIN:   next_state = COMPARE;
            COMPARE: begin
                acc_clr    = 1'b1;
                next_state = (angle == LAST_ANGLE) ? REPORT : SETTLE;
            end
            REPORT:  next_state = bus.continuous ? SETTLE : IDLE;
            default: next_state = IDLE;
        endcase
        if (aborting) begin
            next_state = IDLE;
            acc_clr    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            angle        <= '0;
            best         <= '0;
            best_angle   <= '0;
            first        <= 1'b0;
            settle_cnt   <= '0;
            doa_est_q    <= '0;
            doa_energy_q <= '0;
            doa_valid_q  <= 1'b0;
        end else begin
            state       <= next_state;
            doa_valid_q <= 1'b0;
            if (state == SETTLE && next_state == SETTLE) begin
                if (bus.pcm_valid) settle_cnt <= settle_cnt + 8'd1;
            end else begin
                settle_cnt <= '0;
            end
            if (aborting) begin
                angle <= '0;
            end else begin
                case (state)
                    IDLE, REPORT: begin
                        if ((state == IDLE && bus.start) || (state == REPORT && bus.continuous)) begin
                            angle      <= '0;
                            best       <= '0;
                            best_angle <= '0;
                            first      <= 1'b1;
                        end
                    end
                    COMPARE: begin
                        best       <= new_best;
                        best_angle <= new_angle;
                        first      <= 1'b0;
                        // Publish on entry to REPORT so doa_valid is high during the REPORT cycle.
                        if (angle == LAST_ANGLE) begin
                            if (publish) begin
                                doa_est_q    <= new_angle;
                                doa_energy_q <= new_best;
                                doa_valid_q  <= 1'b1;
                            end
                        end else begin
                            angle <= angle + STEP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.beam_enable  = (state != IDLE);
    assign bus.beam_angle   = angle;
    assign bus.doa_estimate = doa_est_q;
    assign bus.doa_energy   = doa_energy_q;
    assign bus.doa_valid    = doa_valid_q;
endmodule

// File: tb/tb_beam_scan_controller.sv
// Bench for beam_scan_controller: per-angle PCM levels, model picks the first strictly-highest window energy.
// Compile with BEAM_SCAN_THRESH_EN to also exercise the threshold gate.
module tb_beam_scan_controller;
    import beam_pkg::*;

    localparam int STEP = 512, SETTLE_N = 2, WLOG = 2, NPOS = 4, WIN = 4, AW = 34;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    beam_scan_controller_if #(.WINDOW_LOG2(WLOG)) bus ();

    beam_scan_controller #(
        .ANGLE_STEP(STEP), .SETTLE_SAMPLES(SETTLE_N), .WINDOW_LOG2(WLOG)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic signed [15:0] pos_val [NPOS];
    bit valid_every = 1'b0;
    int phase = 0;
    logic [10:0]   last_est = '0;
    logic [AW-1:0] last_en  = '0;

    assign bus.pcm_data = pos_val[2'(bus.beam_angle / 11'(STEP))];

    always @(negedge clk) begin
        phase = (phase + 1) % 4;
        bus.pcm_valid = valid_every || (phase == 0);
    end

    // Each position sees a constant level, so its window energy is WIN * level^2.
    function automatic void model(output logic [10:0] ang, output logic [AW-1:0] en);
        logic [AW-1:0] e;
        ang = '0;
        en  = '0;
        for (int k = 0; k < NPOS; k++) begin
            e = AW'(longint'(WIN) * (longint'(pos_val[k]) * longint'(pos_val[k])));
            if (k == 0 || e > en) begin
                en  = e;
                ang = 11'(k * STEP);
            end
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic wait_doa(input int limit, output bit seen, output int cycles);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (bus.doa_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.beam_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %0b want 0", bus.beam_enable); end
        checks++; if (bus.beam_angle !== 11'd0) begin errors++; $display("FAIL reset_angle got %0d want 0", bus.beam_angle); end
        checks++; if (bus.doa_valid !== 1'b0) begin errors++; $display("FAIL reset_doa_valid got %0b want 0", bus.doa_valid); end
        checks++; if (bus.doa_estimate !== 11'd0) begin errors++; $display("FAIL reset_doa_est got %0d want 0", bus.doa_estimate); end
        checks++; if (bus.doa_energy !== '0) begin errors++; $display("FAIL reset_doa_energy got %0d want 0", bus.doa_energy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Runs one non-continuous sweep with pos_val already set and checks it against want_est/want_en.
    task automatic run_sweep(input string name, input logic [10:0] want_est, input logic [AW-1:0] want_en);
        bit seen;
        int cyc;
        pulse_start();
        checks++; if (bus.busy !== 1'b1 || bus.beam_enable !== 1'b1) begin errors++; $display("FAIL %s_busy_after_start got %0b/%0b want 1/1", name, bus.busy, bus.beam_enable); end
        checks++; if (bus.beam_angle !== 11'd0) begin errors++; $display("FAIL %s_start_angle got %0d want 0", name, bus.beam_angle); end
        wait_doa(400, seen, cyc);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL %s_doa_timeout got no doa_valid want pulse within 400 cycles", name); end
        checks++; if (bus.doa_estimate !== want_est) begin errors++; $display("FAIL %s_est got %0d want %0d", name, bus.doa_estimate, want_est); end
        checks++; if (bus.doa_energy !== want_en) begin errors++; $display("FAIL %s_energy got %0d want %0d", name, bus.doa_energy, want_en); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.doa_valid !== 1'b0) begin errors++; $display("FAIL %s_end got busy %0b valid %0b want 0 0", name, bus.busy, bus.doa_valid); end
        last_est = want_est;
        last_en  = want_en;
    endtask

    task automatic test_peak();
        pos_val = '{16'sd10, 16'sd10, 16'sd100, 16'sd10};
        run_sweep("peak", 11'd1024, 34'd40000);
    endtask

    task automatic test_tie();
        pos_val = '{-16'sd5, -16'sd5, -16'sd5, -16'sd5};
        run_sweep("tie", 11'd0, 34'd100);
    endtask

    task automatic test_fullscale();
        pos_val = '{16'sd0, 16'sd0, 16'sd0, -16'sd32768};
        run_sweep("fullscale", 11'd1536, 34'h1_0000_0000);
    endtask

    task automatic test_random();
        logic [10:0]   m_est;
        logic [AW-1:0] m_en;
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < NPOS; k++) begin
                if (s % 2 == 1) pos_val[k] = 16'(int'($urandom_range(0, 4)) - 2);
                else            pos_val[k] = 16'($urandom);
            end
            model(m_est, m_en);
            run_sweep("random", m_est, m_en);
        end
    endtask

    task automatic test_abort();
        int n;
        int pulses;
        pos_val = '{16'sd7, 16'sd300, 16'sd9, 16'sd1};
        pulse_start();
        n = 0;
        while (bus.beam_angle !== 11'd512 && n < 200) begin @(negedge clk); n++; end
        checks++; if (bus.beam_angle !== 11'd512) begin errors++; $display("FAIL abort_reach512 got %0d want 512", bus.beam_angle); end
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        checks++; if (bus.beam_angle !== 11'd512 || bus.busy !== 1'b1) begin errors++; $display("FAIL busy_start_ignored got angle %0d busy %0b want 512 1", bus.beam_angle, bus.busy); end
        bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", bus.busy); end
        checks++; if (bus.beam_angle !== 11'd0) begin errors++; $display("FAIL abort_angle got %0d want 0", bus.beam_angle); end
        pulses = 0;
        for (int i = 0; i < 150; i++) begin @(negedge clk); if (bus.doa_valid === 1'b1) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_report got %0d pulses want 0", pulses); end
        checks++; if (bus.doa_estimate !== last_est || bus.doa_energy !== last_en) begin errors++; $display("FAIL abort_retain got %0d/%0d want %0d/%0d", bus.doa_estimate, bus.doa_energy, last_est, last_en); end
    endtask

    task automatic test_continuous();
        logic [10:0]   m_est;
        logic [AW-1:0] m_en;
        bit seen;
        int cyc;
        valid_every = 1'b1;
        for (int k = 0; k < NPOS; k++) pos_val[k] = 16'($urandom);
        model(m_est, m_en);
        bus.continuous = 1'b1;
        pulse_start();
        wait_doa(200, seen, cyc);
        checks++; if (seen !== 1'b1 || bus.doa_estimate !== m_est || bus.doa_energy !== m_en) begin errors++; $display("FAIL cont_first got seen %0b est %0d en %0d want 1 %0d %0d", seen, bus.doa_estimate, bus.doa_energy, m_est, m_en); end
        for (int r = 0; r < 2; r++) begin
            wait_doa(200, seen, cyc);
            checks++; if (seen !== 1'b1 || cyc !== 33) begin errors++; $display("FAIL cont_period got seen %0b after %0d cycles want 1 after 33", seen, cyc); end
            checks++; if (bus.doa_estimate !== m_est) begin errors++; $display("FAIL cont_est got %0d want %0d", bus.doa_estimate, m_est); end
        end
        repeat (12) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.beam_enable !== 1'b0 || bus.doa_valid !== 1'b0) begin errors++; $display("FAIL async_reset_flags got %0b%0b%0b want 000", bus.busy, bus.beam_enable, bus.doa_valid); end
        checks++; if (bus.beam_angle !== 11'd0 || bus.doa_estimate !== 11'd0 || bus.doa_energy !== '0) begin errors++; $display("FAIL async_reset_values got %0d %0d %0d want 0 0 0", bus.beam_angle, bus.doa_estimate, bus.doa_energy); end
        @(negedge clk);
        reset = 1'b0;
        bus.continuous = 1'b0;
        valid_every = 1'b0;
        last_est = '0;
        last_en  = '0;
        @(negedge clk);
    endtask

`ifdef BEAM_SCAN_THRESH_EN
    task automatic test_thresh();
        bit seen;
        int cyc;
        pos_val = '{16'sd10, 16'sd10, 16'sd100, 16'sd10};
        bus.energy_thresh = 34'd50000;
        pulse_start();
        wait_doa(400, seen, cyc);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL thresh_block got doa_valid want none"); end
        checks++; if (bus.busy !== 1'b0 || bus.doa_estimate !== last_est || bus.doa_energy !== last_en) begin errors++; $display("FAIL thresh_hold got busy %0b est %0d en %0d want 0 %0d %0d", bus.busy, bus.doa_estimate, bus.doa_energy, last_est, last_en); end
        bus.energy_thresh = 34'd40000;
        run_sweep("thresh_pass", 11'd1024, 34'd40000);
        bus.energy_thresh = '0;
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.continuous = 1'b0;
        bus.abort = 1'b0;
`ifdef BEAM_SCAN_THRESH_EN
        bus.energy_thresh = '0;
`endif
        for (int k = 0; k < NPOS; k++) pos_val[k] = '0;
        test_reset();
        test_peak();
        test_tie();
        test_fullscale();
        test_random();
        test_abort();
        test_continuous();
        test_peak();
`ifdef BEAM_SCAN_THRESH_EN
        test_thresh();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/beam_scan_controller.md
# beam_scan_controller

Sequencer that sweeps the beamformer steering angle around the full circle, measures beamformed output energy at each position, and reports the highest-energy angle as a direction-of-arrival estimate. Sits between the beamforming datapath (drives `beam_angle`/`beam_enable`, consumes `pcm_data`/`pcm_valid`) and the DoA display/consumer (`doa_estimate`/`doa_valid`). Runs in the PCM clock domain.

## Interface
- `ANGLE_STEP`, 64: angle increment in 11-bit angle units; power of 2, 1..1024; positions `NPOS = 2048/ANGLE_STEP`.
- `SETTLE_SAMPLES`, 48: `pcm_valid` samples discarded after each retune (delay-line refill); range 0..255.
- `WINDOW_LOG2`, 8: energy window of `2**WINDOW_LOG2` samples; range 1..12.
- `clk` in 1: PCM-domain clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request to begin a sweep; ignored while `busy`.
- `continuous` in 1: sampled in REPORT; 1 = immediately start the next sweep.
- `abort` in 1: cancel the sweep in progress.
- `pcm_data` in 16: signed beamformed sample.
- `pcm_valid` in 1: `pcm_data` qualifier.
- `beam_angle` out 11: steering angle to the datapath.
- `beam_enable` out 1: high whenever `busy`.
- `busy` out 1: high in any state other than IDLE.
- `doa_estimate` out 11: best angle of the last completed sweep.
- `doa_energy` out `32+WINDOW_LOG2`: energy at `doa_estimate`.
- `doa_valid` out 1: one-cycle pulse when a new estimate is published.
- `energy_thresh` in `32+WINDOW_LOG2`: present only with `BEAM_SCAN_THRESH_EN`.

## Operation
- States: IDLE, SETTLE, ACCUM, DRAIN, COMPARE, REPORT.
- IDLE: `start` goes to SETTLE and clears the angle, best energy and first flag.
- SETTLE: counts `SETTLE_SAMPLES` valid samples, then enters ACCUM. With 0 it enters ACCUM on the next cycle.
- ACCUM: each valid sample is squared (signed 16x16 to unsigned 32) into a one-stage register, then added to the accumulator. After `2**WINDOW_LOG2` valid samples it enters DRAIN.
- DRAIN: one cycle so the last square reaches the accumulator. Then COMPARE.
- COMPARE:
  - Updates best if this is the first position or `acc > best`, strictly greater, so a tie keeps the lower angle.
  - Clears the accumulator.
  - If `beam_angle == 2048-ANGLE_STEP`, goes to REPORT; otherwise adds `ANGLE_STEP` to the angle (mod 2048) and returns to SETTLE.
- REPORT:
  - Loads `doa_estimate`/`doa_energy` from best and pulses `doa_valid`.
  - If `continuous`, goes to SETTLE with the angle at 0 and best cleared; otherwise goes to IDLE.
- Accumulator width is `32+WINDOW_LOG2` and cannot overflow. Full-scale -32768 gives 2^30 per sample.
- `abort` in any non-IDLE state goes to IDLE next cycle: no report, `beam_angle` set to 0, accumulator cleared, `doa_*` keep their previous values. `abort` has priority over `start`/`continuous`.
- `pcm_valid` is ignored in IDLE, DRAIN, COMPARE and REPORT.

## Timing
- Reset values: all outputs 0, state IDLE.
- `start` at cycle t gives `busy`/`beam_enable` = 1 at t+1, with `beam_angle` = 0.
- Per position: `SETTLE_SAMPLES + 2**WINDOW_LOG2` valid samples, plus 2 cycles (DRAIN, COMPARE).
- `doa_valid` is asserted the cycle after the last COMPARE. In non-continuous mode `busy` falls the cycle after `doa_valid`.
- `beam_angle` changes only on the COMPARE to SETTLE transition, on abort, and on restart.

## Configuration
- `BEAM_SCAN_THRESH_EN`:
  - Defined: REPORT publishes only if best energy >= `energy_thresh`. Otherwise there is no `doa_valid` and `doa_*` hold their old values; state transitions are unchanged.
  - Undefined: the port is absent and every sweep publishes.

## Structure
- Package `beam_pkg`: `ANGLE_W=11`, `PCM_W=16`, `ANGLE_FULL=2048`, state enum `scan_state_t`.
- Sub-module `energy_accumulator`: square register, accumulator, sample counter, `done` flag. The FSM instantiates one.

## Test plan
Common parameters: `ANGLE_STEP=512`, `SETTLE_SAMPLES=2`, `WINDOW_LOG2=2`, `pcm_valid` every 4th cycle.
- Bench drives pcm = 100 when `beam_angle == 1024`, else 10, then pulses `start` -> one `doa_valid`, `doa_estimate=1024`, `doa_energy=40000`, `busy` low afterwards.
- Constant pcm = -5 -> all four positions tie at 100 -> `doa_estimate=0`, `doa_energy=100`.
- pcm = -32768 at angle 1536 -> `doa_estimate=1536`, `doa_energy=2^32` (no overflow).
- `abort` during ACCUM at angle 512 -> IDLE next cycle, `beam_angle=0`, no `doa_valid`, previous `doa_*` retained; `start` while busy has no effect.
- `continuous=1` -> `doa_valid` pulses repeat every `4*(6 valid + 2) + 1` sweep; an async `reset` mid-sweep gives all outputs 0 immediately.
- With `BEAM_SCAN_THRESH_EN`: `energy_thresh=50000` and peak 40000 -> no `doa_valid`; `energy_thresh=40000` -> published.
